// File: rtl/img_capture_packer.sv
// Frame-capture engine: arms on a start request, waits for a frame start and packs
// IMG_PIXELS pixels into PIX_PER_WORD-lane memory words. Optional macro: IMGCAP_CONTINUOUS_EN.
module img_capture_packer #(
  parameter int PIX_W        = 16,
  parameter int PIX_PER_WORD = 16,
  parameter int IMG_PIXELS   = 784,
  parameter int ADDR_W       = 7
) (
  input  logic                          pxlclk,
  input  logic                          rst,
  input  logic                          iEnable,
  input  logic                          iStart,
  input  logic                          iFVAL,
  input  logic                          iDVAL,
  input  logic [PIX_W-1:0]              iDATA,
  output logic                          oDmem_wren,
  output logic [ADDR_W-1:0]             oDmem_addr,
  output logic [PIX_W*PIX_PER_WORD-1:0] oDmem_data,
  output logic [1:0]                    oState,
  output logic                          oBusy,
  output logic                          oDone,
  output logic                          oFrameErr,
  output logic                          frame_val
);

  localparam int WORD_W = PIX_W * PIX_PER_WORD;
  localparam int CNT_W  = $clog2(IMG_PIXELS + 1);
  localparam int LANE_W = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
  localparam logic [CNT_W-1:0]  LAST_PIX  = CNT_W'(IMG_PIXELS - 1);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PIX_PER_WORD - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, CAPTURE = 2'd2, DONE = 2'd3} state_t;

  state_t              state;
  logic                fval_q, dval_q, start_q, fval_q_d, start_q_d;
  logic [PIX_W-1:0]    data_q;
  logic [CNT_W-1:0]    pxl_cnt;
  logic [LANE_W-1:0]   lane_idx;
  logic [ADDR_W-1:0]   word_idx;
  logic [WORD_W-1:0]   buf_q;
  logic [WORD_W-1:0]   word_next;
  logic                start_rise, fval_rise, last_pix, last_lane;

  always_ff @(posedge pxlclk or posedge rst) begin
    if (rst) begin
      fval_q    <= 1'b0;
      dval_q    <= 1'b0;
      start_q   <= 1'b0;
      data_q    <= '0;
      fval_q_d  <= 1'b0;
      start_q_d <= 1'b0;
    end else begin
      // NOTE: non-blocking everywhere here so every register samples the pre-edge values.
      fval_q    <= iFVAL;
      dval_q    <= iDVAL;
      start_q   <= iStart;
      data_q    <= iDATA;
      fval_q_d  <= fval_q;
      start_q_d <= start_q;
    end
  end

  assign start_rise = start_q & ~start_q_d;
  assign fval_rise  = fval_q & ~fval_q_d;
  assign last_pix   = (pxl_cnt == LAST_PIX);
  assign last_lane  = (lane_idx == LAST_LANE);
  assign frame_val  = fval_q;
  assign oState     = state;

  // Lanes above lane_idx are still zero in the buffer, so OR-ing the new pixel in also pads.
  always_comb begin
    // NOTE: default assignment first so no path through this block can infer a latch.
    word_next = buf_q;
    word_next = word_next | (WORD_W'(data_q) << (lane_idx * PIX_W));
  end

  always_ff @(posedge pxlclk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pxl_cnt    <= '0;
      lane_idx   <= '0;
      word_idx   <= '0;
      // NOTE: the working buffer is reset too, since zero lanes double as the padding.
      buf_q      <= '0;
      oDmem_wren <= 1'b0;
      oDmem_addr <= '0;
      oDmem_data <= '0;
      oBusy      <= 1'b0;
      oDone      <= 1'b0;
      oFrameErr  <= 1'b0;
    end else begin
      oDmem_wren <= 1'b0;
      oDone      <= 1'b0;
      oFrameErr  <= 1'b0;
      if (state != CAPTURE) begin
        pxl_cnt  <= '0;
        lane_idx <= '0;
        word_idx <= '0;
        buf_q    <= '0;
      end
      case (state)
        IDLE: begin
          if (iEnable && start_rise) begin
            state <= ARM;
            oBusy <= 1'b1;
          end
        end
        ARM: begin
          if (!iEnable) begin
            state <= IDLE;
            oBusy <= 1'b0;
          end else if (fval_rise) begin
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (!iEnable) begin
            state <= IDLE;
            oBusy <= 1'b0;
          end else if (dval_q && (fval_q || last_pix)) begin
            pxl_cnt <= pxl_cnt + CNT_W'(1);
            if (last_lane || last_pix) begin
              oDmem_data <= word_next;
              oDmem_addr <= word_idx;
              oDmem_wren <= 1'b1;
              word_idx   <= word_idx + ADDR_W'(1);
              buf_q      <= '0;
              lane_idx   <= '0;
            end else begin
              buf_q    <= word_next;
              lane_idx <= lane_idx + LANE_W'(1);
            end
            if (last_pix) begin
              state <= DONE;
              oBusy <= 1'b0;
            end
          end else if (!fval_q) begin
            // Truncated frame: drop the partial word and retry on the next frame.
            state     <= ARM;
            oFrameErr <= 1'b1;
            pxl_cnt   <= '0;
            lane_idx  <= '0;
            word_idx  <= '0;
            buf_q     <= '0;
          end
        end
        DONE: begin
          oDone <= 1'b1;
`ifdef IMGCAP_CONTINUOUS_EN
          if (iEnable) begin
            state <= ARM;
            oBusy <= 1'b1;
          end else begin
            state <= IDLE;
          end
`else
          state <= IDLE;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_img_capture_packer.sv
// Directed self-checking bench for img_capture_packer: a default 784x16 instance and a
// small 20-pixel / 8-lane instance, each with its own stimulus and write monitor.
module tb_img_capture_packer;

  logic pxlclk = 1'b0;
  logic rst    = 1'b1;
  always #5 pxlclk = ~pxlclk;

  // Default-parameter instance
  logic         iEnable = 0, iStart = 0, iFVAL = 0, iDVAL = 0;
  logic [15:0]  iDATA = '0;
  logic         oDmem_wren, oBusy, oDone, oFrameErr, frame_val;
  logic [6:0]   oDmem_addr;
  logic [255:0] oDmem_data;
  logic [1:0]   oState;

  img_capture_packer dut (
    .pxlclk(pxlclk), .rst(rst), .iEnable(iEnable), .iStart(iStart), .iFVAL(iFVAL),
    .iDVAL(iDVAL), .iDATA(iDATA), .oDmem_wren(oDmem_wren), .oDmem_addr(oDmem_addr),
    .oDmem_data(oDmem_data), .oState(oState), .oBusy(oBusy), .oDone(oDone),
    .oFrameErr(oFrameErr), .frame_val(frame_val)
  );

  // Small instance: 8 lanes, 20 pixels
  logic         s_en = 0, s_start = 0, s_fval = 0, s_dval = 0;
  logic [15:0]  s_data = '0;
  logic         s_wren, s_busy, s_done, s_err, s_fv;
  logic [1:0]   s_addr;
  logic [127:0] s_wdata;
  logic [1:0]   s_state;

  img_capture_packer #(.PIX_W(16), .PIX_PER_WORD(8), .IMG_PIXELS(20), .ADDR_W(2)) dut_s (
    .pxlclk(pxlclk), .rst(rst), .iEnable(s_en), .iStart(s_start), .iFVAL(s_fval),
    .iDVAL(s_dval), .iDATA(s_data), .oDmem_wren(s_wren), .oDmem_addr(s_addr),
    .oDmem_data(s_wdata), .oState(s_state), .oBusy(s_busy), .oDone(s_done),
    .oFrameErr(s_err), .frame_val(s_fv)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge pxlclk) cyc <= cyc + 1;

  // Write monitors, sampled on the falling edge
  logic [255:0] wq[$];
  int           aq[$];
  int           n_done = 0, n_err = 0, done_orphan = 0;
  logic         wren_d = 1'b0;
  logic [127:0] sq[$];
  int           saq[$];
  int           s_ndone = 0, s_nerr = 0, s_last_wr_cyc = 0;

  always @(negedge pxlclk) begin
    if (!rst) begin
      if (oDmem_wren) begin
        wq.push_back(oDmem_data);
        aq.push_back(int'(oDmem_addr));
      end
      if (oDone) begin
        n_done++;
        if (!wren_d) done_orphan++;
      end
      if (oFrameErr) n_err++;
      wren_d = oDmem_wren;
      if (s_wren) begin
        sq.push_back(s_wdata);
        saq.push_back(int'(s_addr));
        s_last_wr_cyc = cyc;
      end
      if (s_done) s_ndone++;
      if (s_err) s_nerr++;
    end
  end

  function automatic logic [255:0] big_word(input int w);
    logic [255:0] v = '0;
    for (int i = 0; i < 16; i++) begin
      if (16 * w + i < 784) v[i*16 +: 16] = 16'(16 * w + i);
    end
    return v;
  endfunction

  function automatic logic [255:0] small_word(input int w);
    logic [255:0] v = '0;
    for (int i = 0; i < 8; i++) begin
      if (8 * w + i < 20) v[i*16 +: 16] = 16'(8 * w + i + 1);
    end
    return v;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge pxlclk);
  endtask

  task automatic pulse_start();
    iStart = 1'b1;
    tick(2);
    iStart = 1'b0;
    tick(3);
  endtask

  // Drives n pixels valued base+i, with a one-cycle DVAL gap after every 7th pixel.
  task automatic send_pixels(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      iDVAL = 1'b1;
      iDATA = 16'(base + i);
      tick(1);
      if (i % 7 == 6) begin
        iDVAL = 1'b0;
        tick(1);
      end
    end
    iDVAL = 1'b0;
  endtask

  task automatic send_frame(input int n);
    iFVAL = 1'b1;
    tick(3);
    send_pixels(n, 0);
    tick(3);
    iFVAL = 1'b0;
    tick(4);
  endtask

  // Checks a complete 49-word capture starting at queue position base.
  task automatic check_full(input string tag, input int base);
    int n;
    n = wq.size() - base;
    check({tag, "_nwr"}, 256'(n), 256'(49));
    for (int w = 0; w < 49 && w < n; w++) begin
      check($sformatf("%s_addr%0d", tag, w), 256'(aq[base + w]), 256'(w));
      check($sformatf("%s_data%0d", tag, w), wq[base + w], big_word(w));
    end
  endtask

  initial begin
    int bw, bd, be, last_cyc, nfr;

    tick(3);
    check("rst_state", 256'(oState), 256'(0));
    check("rst_wren", 256'(oDmem_wren), 256'(0));
    check("rst_addr", 256'(oDmem_addr), 256'(0));
    check("rst_data", oDmem_data, 256'(0));
    check("rst_flags", 256'({oBusy, oDone, oFrameErr, frame_val}), 256'(0));
    rst = 1'b0;
    tick(2);
    check("idle_state", 256'(oState), 256'(0));

    // Small instance: pixels 1..20 into three 8-lane words
    s_en = 1'b1;
    s_start = 1'b1;
    tick(2);
    s_start = 1'b0;
    tick(3);
    check("s_arm", 256'(s_state), 256'(1));
    s_fval = 1'b1;
    tick(3);
    last_cyc = 0;
    for (int i = 0; i < 20; i++) begin
      s_dval = 1'b1;
      s_data = 16'(i + 1);
      last_cyc = cyc;
      tick(1);
    end
    s_dval = 1'b0;
    tick(3);
    s_fval = 1'b0;
    tick(4);
    check("s_nwr", 256'(sq.size()), 256'(3));
    for (int w = 0; w < 3 && w < sq.size(); w++) begin
      check($sformatf("s_addr%0d", w), 256'(saq[w]), 256'(w));
      check($sformatf("s_data%0d", w), 256'(sq[w]), small_word(w));
    end
    check("s_latency", 256'(s_last_wr_cyc - last_cyc), 256'(2));
    check("s_done", 256'(s_ndone), 256'(1));
    check("s_err", 256'(s_nerr), 256'(0));
    check("s_idle", 256'(s_state), 256'(0));
    s_en = 1'b0;

    // Full 784-pixel frame
    iEnable = 1'b1;
    pulse_start();
    check("t1_arm", 256'(oState), 256'(1));
    check("t1_busy", 256'(oBusy), 256'(1));
    bw = wq.size(); bd = n_done; be = n_err;
    send_frame(784);
    check_full("t1", bw);
    check("t1_done", 256'(n_done - bd), 256'(1));
    check("t1_err", 256'(n_err - be), 256'(0));
    check("t1_idle", 256'(oState), 256'(0));
    check("t1_hold", oDmem_data, big_word(48));

    // Start requested while a frame is already running
    bw = wq.size(); bd = n_done;
    iFVAL = 1'b1;
    tick(3);
    send_pixels(10, 16'hA000);
    pulse_start();
    send_pixels(30, 16'hB000);
    check("t2_arm", 256'(oState), 256'(1));
    check("t2_nowr", 256'(wq.size() - bw), 256'(0));
    tick(2);
    iFVAL = 1'b0;
    tick(4);
    send_frame(784);
    check_full("t2", bw);
    check("t2_done", 256'(n_done - bd), 256'(1));

    // Truncated frame after 100 pixels, then a clean retry
    pulse_start();
    bw = wq.size(); bd = n_done; be = n_err;
    send_frame(100);
    check("t3_nwr", 256'(wq.size() - bw), 256'(6));
    for (int w = 0; w < 6 && bw + w < wq.size(); w++)
      check($sformatf("t3_addr%0d", w), 256'(aq[bw + w]), 256'(w));
    check("t3_err", 256'(n_err - be), 256'(1));
    check("t3_arm", 256'(oState), 256'(1));
    check("t3_nodone", 256'(n_done - bd), 256'(0));
    bw = wq.size();
    send_frame(784);
    check_full("t3r", bw);
    check("t3r_done", 256'(n_done - bd), 256'(1));
    check("t3r_err", 256'(n_err - be), 256'(1));

    // Enable dropped mid-capture, with a repeated start while busy
    pulse_start();
    bw = wq.size(); bd = n_done; be = n_err;
    iFVAL = 1'b1;
    tick(3);
    send_pixels(20, 0);
    check("t4_capture", 256'(oState), 256'(2));
    check("t4_fval", 256'(frame_val), 256'(1));
    iStart = 1'b1;
    send_pixels(10, 20);
    iStart = 1'b0;
    send_pixels(20, 30);
    check("t4_restart_ignored", 256'(oState), 256'(2));
    iEnable = 1'b0;
    tick(1);
    check("t4_idle", 256'(oState), 256'(0));
    check("t4_notbusy", 256'(oBusy), 256'(0));
    send_pixels(30, 50);
    tick(3);
    iFVAL = 1'b0;
    tick(4);
    check("t4_nwr", 256'(wq.size() - bw), 256'(3));
    check("t4_nodone", 256'(n_done - bd), 256'(0));
    check("t4_noerr", 256'(n_err - be), 256'(0));

    // Three back-to-back frames after a single start
    iEnable = 1'b1;
    pulse_start();
    bw = wq.size(); bd = n_done;
    for (int f = 0; f < 3; f++) send_frame(784);
`ifdef IMGCAP_CONTINUOUS_EN
    nfr = 3;
`else
    nfr = 1;
`endif
    check("t5_nwr", 256'(wq.size() - bw), 256'(49 * nfr));
    check("t5_done", 256'(n_done - bd), 256'(nfr));
    check_full("t5", bw);
    iEnable = 1'b0;
    tick(2);
    check("t5_idle", 256'(oState), 256'(0));

    // Reset asserted mid-capture
    iEnable = 1'b1;
    pulse_start();
    bw = wq.size();
    iFVAL = 1'b1;
    tick(3);
    send_pixels(30, 0);
    check("t6_busy", 256'(oBusy), 256'(1));
    rst = 1'b1;
    tick(1);
    check("t6_state", 256'(oState), 256'(0));
    check("t6_addr", 256'(oDmem_addr), 256'(0));
    check("t6_data", oDmem_data, 256'(0));
    check("t6_busy0", 256'(oBusy), 256'(0));
    rst = 1'b0;
    send_pixels(20, 0);
    tick(3);
    iFVAL = 1'b0;
    iEnable = 1'b0;
    tick(4);
    check("t6_nwr", 256'(wq.size() - bw), 256'(1));
    check("t6_state_after", 256'(oState), 256'(0));

    check("done_after_wren", 256'(done_orphan), 256'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
